// File: rtl/alu_pmu_pkg.sv
// Shared definitions for the PD_ALU power sequencer: state encoding, per-state
// control values, ALU opcodes and default delays.
package alu_pmu_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ON      = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISO     = 3'd2,
        ST_SAVE    = 3'd3,
        ST_OFF     = 3'd4,
        ST_PWRUP   = 3'd5,
        ST_RESTORE = 3'd6
    } pwr_state_e;

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    localparam int unsigned DEF_ISO_CYC      = 2;
    localparam int unsigned DEF_PWRUP_CYC    = 4;
    localparam int unsigned DEF_IDLE_TIMEOUT = 0;
    localparam int unsigned DEF_CNT_W        = 8;

    typedef struct packed {
        logic pwr_en;
        logic iso_en;
        logic save;
        logic restore;
        logic pwr_ready;
        logic sleep_ack;
    } pwr_ctrl_t;

    // Domain control values held while in a given state.
    function automatic pwr_ctrl_t ctrl_of(input pwr_state_e s);
        pwr_ctrl_t c;
        c = '0;
        case (s)
            ST_ON: begin
                c.pwr_en    = 1'b1;
                c.pwr_ready = 1'b1;
            end
            ST_DRAIN: c.pwr_en = 1'b1;
            ST_ISO, ST_PWRUP: begin
                c.pwr_en = 1'b1;
                c.iso_en = 1'b1;
            end
            ST_SAVE: begin
                c.pwr_en = 1'b1;
                c.iso_en = 1'b1;
                c.save   = 1'b1;
            end
            ST_OFF: begin
                c.iso_en    = 1'b1;
                c.sleep_ack = 1'b1;
            end
            ST_RESTORE: begin
                c.pwr_en  = 1'b1;
                c.iso_en  = 1'b1;
                c.restore = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pmu_delay_timer.sv
// Load/count/done counter timing the ISO and PWRUP dwell windows.
module pmu_delay_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] last_val,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == last_val);

endmodule

// File: rtl/alu_pwr_seq_ctrl.sv
// PD_ALU power sequencer: drain, isolate, save, power off, and the reverse on
// wake; gates ALU starts and optionally auto-sleeps after an idle timeout.
module alu_pwr_seq_ctrl
    import alu_pmu_pkg::*;
#(
    parameter int unsigned ISO_CYC      = DEF_ISO_CYC,
    parameter int unsigned PWRUP_CYC    = DEF_PWRUP_CYC,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sleep_req,
    input  logic               wake_req,
    input  logic               start_in,
    input  logic               alu_busy,
    output logic               alu_start,
    output logic               alu_pwr_en,
    output logic               iso_en,
    output logic               save,
    output logic               restore,
    output logic               pwr_ready,
    output logic               sleep_ack,
    output logic [STATE_W-1:0] pwr_state
);

    localparam logic [CNT_W-1:0] ISO_LAST   = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LIM   = CNT_W'(IDLE_TIMEOUT);
    localparam bit               IDLE_EN    = (IDLE_TIMEOUT != 0);

    pwr_state_e       state_q, state_d;
    pwr_ctrl_t        ctrl_q, ctrl_d;
    logic             load_c, count_en_c, delay_done_c, idle_hit_c;
    logic [CNT_W-1:0] delay_last_c;
    logic [CNT_W-1:0] idle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ON;
            ctrl_q  <= ctrl_of(ST_ON);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next state; control flops are loaded from the decode of the next state.
    always_comb begin
        state_d      = state_q;
        count_en_c   = 1'b0;
        delay_last_c = ISO_LAST;
        case (state_q)
            ST_ON: begin
                if (!wake_req && (sleep_req || idle_hit_c)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wake_req)       state_d = ST_ON;
                else if (!alu_busy) state_d = ST_ISO;
            end
            ST_ISO: begin
                count_en_c = 1'b1;
                if (delay_done_c) state_d = ST_SAVE;
            end
            ST_SAVE:  state_d = ST_OFF;
            ST_OFF: begin
                if (wake_req) state_d = ST_PWRUP;
            end
            ST_PWRUP: begin
                count_en_c   = 1'b1;
                delay_last_c = PWRUP_LAST;
                if (delay_done_c) state_d = ST_RESTORE;
            end
            ST_RESTORE: state_d = ST_ON;
            default:    state_d = ST_ON;
        endcase
        ctrl_d = ctrl_of(state_d);
        load_c = ((state_d == ST_ISO)   && (state_q != ST_ISO)) ||
                 ((state_d == ST_PWRUP) && (state_q != ST_PWRUP));
    end

    pmu_delay_timer #(
        .CNT_W(CNT_W)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .en       (count_en_c),
        .last_val (delay_last_c),
        .done_c   (delay_done_c)
    );

    // Idle counter saturates at the timeout so the hit stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (!IDLE_EN || (state_q != ST_ON) || start_in || alu_busy) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IDLE_LIM) begin
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
    end

    assign idle_hit_c = IDLE_EN && (idle_cnt_q == IDLE_LIM);

    assign alu_start  = start_in && (state_q == ST_ON);
    assign alu_pwr_en = ctrl_q.pwr_en;
    assign iso_en     = ctrl_q.iso_en;
    assign save       = ctrl_q.save;
    assign restore    = ctrl_q.restore;
    assign pwr_ready  = ctrl_q.pwr_ready;
    assign sleep_ack  = ctrl_q.sleep_ack;
    assign pwr_state  = state_q;

endmodule

// File: tb/tb_alu_pwr_seq_ctrl.sv
// Self-checking bench for alu_pwr_seq_ctrl: directed table, corner-case
// sequences and random traffic against a dwell-based reference model.
module tb_alu_pwr_seq_ctrl;

    localparam int ISO_N   = 2;
    localparam int PWRUP_N = 4;
    localparam int IDLE_B  = 5;

    logic clk = 1'b0;
    logic rst_n, sleep_req, wake_req, start_in, alu_busy;

    logic       a_start, a_pwr_en, a_iso, a_save, a_restore, a_ready, a_ack;
    logic [2:0] a_state;
    logic       b_start, b_pwr_en, b_iso, b_save, b_restore, b_ready, b_ack;
    logic [2:0] b_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pwr_seq_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
        .start_in(start_in), .alu_busy(alu_busy), .alu_start(a_start),
        .alu_pwr_en(a_pwr_en), .iso_en(a_iso), .save(a_save), .restore(a_restore),
        .pwr_ready(a_ready), .sleep_ack(a_ack), .pwr_state(a_state)
    );

    alu_pwr_seq_ctrl #(.IDLE_TIMEOUT(IDLE_B)) u_idle (
        .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
        .start_in(start_in), .alu_busy(alu_busy), .alu_start(b_start),
        .alu_pwr_en(b_pwr_en), .iso_en(b_iso), .save(b_save), .restore(b_restore),
        .pwr_ready(b_ready), .sleep_ack(b_ack), .pwr_state(b_state)
    );

    // Reference model: state number plus cycles left in a timed dwell and
    // length of the current idle run in ON.
    typedef struct {
        int st;
        int left;
        int idle;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_next(input mdl_t m, input bit slp, input bit wk,
                                      input bit stt, input bit bsy, input int idle_to);
        mdl_t n;
        n = m;
        if (m.st == 0 && idle_to != 0 && !stt && !bsy)
            n.idle = (m.idle + 1 > idle_to) ? idle_to : m.idle + 1;
        else
            n.idle = 0;
        case (m.st)
            0: if (!wk && (slp || (idle_to != 0 && m.idle == idle_to))) n.st = 1;
            1: begin
                if (wk) n.st = 0;
                else if (!bsy) begin n.st = 2; n.left = ISO_N; end
            end
            2: begin
                if (m.left > 1) n.left = m.left - 1;
                else n.st = 3;
            end
            3: n.st = 4;
            4: if (wk) begin n.st = 5; n.left = PWRUP_N; end
            5: begin
                if (m.left > 1) n.left = m.left - 1;
                else n.st = 6;
            end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    // {pwr_en, iso_en, save, restore, pwr_ready, sleep_ack} per state
    function automatic logic [5:0] exp_outs(input int st);
        logic [5:0] v;
        case (st)
            0: v = 6'b100010;
            1: v = 6'b100000;
            2: v = 6'b110000;
            3: v = 6'b111000;
            4: v = 6'b010001;
            5: v = 6'b110000;
            6: v = 6'b110100;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

    function automatic logic [8:0] exp_vec(input int st);
        return {3'(st), exp_outs(st)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("dut_a_state_outs",
              32'({a_state, a_pwr_en, a_iso, a_save, a_restore, a_ready, a_ack}),
              32'(exp_vec(ma.st)));
        check("dut_b_state_outs",
              32'({b_state, b_pwr_en, b_iso, b_save, b_restore, b_ready, b_ack}),
              32'(exp_vec(mb.st)));
    endtask

    // Called at posedge+1: drive inputs, check gated start, clock one edge.
    task automatic step(input bit slp, input bit wk, input bit stt, input bit bsy);
        mdl_t na, nb;
        sleep_req = slp;
        wake_req  = wk;
        start_in  = stt;
        alu_busy  = bsy;
        #1;
        check("a_alu_start", 32'(a_start), 32'(stt && ma.st == 0));
        check("b_alu_start", 32'(b_start), 32'(stt && mb.st == 0));
        na = mdl_next(ma, slp, wk, stt, bsy, 0);
        nb = mdl_next(mb, slp, wk, stt, bsy, IDLE_B);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        check_all();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        sleep_req = 1'b0;
        wake_req  = 1'b0;
        start_in  = 1'b0;
        alu_busy  = 1'b0;
        ma = '{0, 0, 0};
        mb = '{0, 0, 0};
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    typedef struct {
        bit slp;
        bit wk;
        bit stt;
        bit bsy;
        int exp_st;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        bit   slp, wk, stt, bsy;
        int   mode;

        // sleep sequence, wake sequence, drain abort and wake-over-sleep
        tbl.push_back('{1, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 2});
        tbl.push_back('{1, 0, 0, 0, 2});
        tbl.push_back('{1, 0, 0, 0, 3});
        tbl.push_back('{1, 0, 0, 0, 4});
        tbl.push_back('{1, 0, 0, 0, 4});
        tbl.push_back('{0, 1, 0, 0, 5});
        tbl.push_back('{0, 1, 0, 0, 5});
        tbl.push_back('{0, 1, 0, 0, 5});
        tbl.push_back('{0, 1, 0, 0, 5});
        tbl.push_back('{0, 1, 0, 0, 6});
        tbl.push_back('{0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1});
        tbl.push_back('{1, 0, 1, 1, 1});
        tbl.push_back('{0, 1, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0});

        rst_n = 1'b0;
        do_reset();
        check("reset_outs_a", 32'({a_state, a_pwr_en, a_iso, a_save, a_restore, a_ready, a_ack}),
              32'(9'b000_100010));

        foreach (tbl[i]) begin
            step(tbl[i].slp, tbl[i].wk, tbl[i].stt, tbl[i].bsy);
            check($sformatf("tbl_%0d", i),
                  32'({a_state, a_pwr_en, a_iso, a_save, a_restore, a_ready, a_ack}),
                  32'(exp_vec(tbl[i].exp_st)));
        end

        // Long divide in flight: DRAIN holds until busy drops.
        do_reset();
        step(1, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, (i % 2) == 1, 1);
            check("div_drain_state", 32'(a_state), 32'(1));
            check("div_drain_iso", 32'(a_iso), 32'(0));
        end
        step(1, 0, 1, 0);
        check("div_iso_after_busy", 32'({a_state, a_iso}), 32'({3'd2, 1'b1}));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("div_reached_off", 32'({a_state, a_pwr_en}), 32'({3'd4, 1'b0}));

        // Idle timeout with no activity.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            check("idle_hold_on", 32'(b_state), 32'(0));
        end
        step(0, 0, 0, 0);
        check("idle_to_drain", 32'(b_state), 32'(1));

        // Start at idle cycle 3 restarts the count.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            check("idle_restart_on", 32'(b_state), 32'(0));
        end
        step(0, 0, 0, 0);
        check("idle_restart_drain", 32'(b_state), 32'(1));

        // Async reset in the middle of PWRUP.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("pre_rst_pwrup", 32'(a_state), 32'(5));
        #3;
        rst_n = 1'b0;
        ma = '{0, 0, 0};
        mb = '{0, 0, 0};
        #1;
        check("rst_mid_pwrup", 32'({a_state, a_pwr_en, a_iso, a_restore}),
              32'({3'd0, 1'b1, 1'b0, 1'b0}));
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Random traffic in phases: quiet, busy-heavy, mixed.
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 64) % 3;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            case (mode)
                0: begin
                    slp = 1'b0;
                    wk  = ($urandom_range(0, 19) == 0);
                    stt = ($urandom_range(0, 29) == 0);
                    bsy = 1'b0;
                end
                1: begin
                    slp = ($urandom_range(0, 3) == 0);
                    wk  = ($urandom_range(0, 7) == 0);
                    stt = ($urandom_range(0, 2) == 0);
                    bsy = ($urandom_range(0, 3) != 0);
                end
                default: begin
                    slp = ($urandom_range(0, 2) == 0);
                    wk  = ($urandom_range(0, 3) == 0);
                    stt = ($urandom_range(0, 1) == 0);
                    bsy = ($urandom_range(0, 2) == 0);
                end
            endcase
            step(slp, wk, stt, bsy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pwr_seq_ctrl.md
Name: alu_pwr_seq_ctrl

Overview:
Power-management sequencer for the ALU power domain (PD_ALU). It drives the ALU's alu_pwr_en, iso_en, save and restore controls in the mandated order: drain, isolate, save, power off, and the reverse on wake. It also gates ALU start requests so no operation launches unless the domain is fully on, and can auto-sleep after an idle timeout. It sits in top, beside the ALU and the always-on block, and is itself always-on.

Parameters:
ISO_CYC, 2, cycles iso_en is held before the save pulse (legal range 1..2^CNT_W-1)
PWRUP_CYC, 4, power-ramp cycles after alu_pwr_en rises, before the restore pulse (legal range 1..2^CNT_W-1)
IDLE_TIMEOUT, 0, number of consecutive idle ON cycles that triggers auto-sleep; 0 disables auto-sleep
CNT_W, 8, width of the delay and idle counters

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
sleep_req  in  1  level request to power down PD_ALU
wake_req  in  1  level request to power up PD_ALU; must be held until pwr_ready
start_in  in  1  requester's ALU start
alu_busy  in  1  busy from the ALU
alu_start  out  1  gated start to the ALU, equal to start_in && (state==ON); combinational
alu_pwr_en  out  1  PD_ALU power enable; registered
iso_en  out  1  PD_ALU output isolation; registered
save  out  1  one-cycle retention save pulse; registered
restore  out  1  one-cycle retention restore pulse; registered
pwr_ready  out  1  high only in ON; registered
sleep_ack  out  1  high only in OFF; registered
pwr_state  out  3  current FSM state encoding

Behaviour:
- States (3-bit encoding): ON=0, DRAIN=1, ISO=2, SAVE=3, OFF=4, PWRUP=5, RESTORE=6.
- All outputs except alu_start are flops. Each is loaded from the next-state decode, so its value always matches the current state. Outputs must be glitch-free.
- Per-state output values:
  - ON: pwr_en=1, iso=0, pwr_ready=1
  - DRAIN: pwr_en=1, iso=0
  - ISO: pwr_en=1, iso=1
  - SAVE: pwr_en=1, iso=1, save=1
  - OFF: pwr_en=0, iso=1, sleep_ack=1
  - PWRUP: pwr_en=1, iso=1
  - RESTORE: pwr_en=1, iso=1, restore=1
- Reset: state ON, alu_pwr_en=1, iso_en=0, save=0, restore=0, pwr_ready=1, sleep_ack=0, all counters 0. Reset asserted mid-sequence returns to ON immediately.
- ON transitions:
  - wake_req=1: stay ON. Wake wins over sleep.
  - else sleep_req=1 or idle timeout reached: go to DRAIN.
- DRAIN:
  - wake_req=1: go to ON (abort).
  - else alu_busy=0: go to ISO.
  - Minimum dwell is 1 cycle. alu_start is blocked throughout.
- ISO: dwell exactly ISO_CYC cycles, then SAVE.
- SAVE: dwell 1 cycle, then OFF.
- OFF: wake_req=1 goes to PWRUP. sleep_req is ignored.
- PWRUP: dwell exactly PWRUP_CYC cycles, then RESTORE.
- RESTORE: dwell 1 cycle, then ON. iso_en falls on ON entry.
- sleep_req and wake_req are ignored in ISO, SAVE, PWRUP and RESTORE; these sequences always complete. A wake_req still held on reaching OFF causes PWRUP on the next cycle.
- Delay counter: cleared on entry to ISO or PWRUP, increments each cycle in that state, and the exit fires when count == N-1.
- Idle counter:
  - Active only in ON with IDLE_TIMEOUT != 0.
  - Cleared whenever start_in, alu_busy, or state!=ON.
  - Otherwise increments, saturating at IDLE_TIMEOUT.
  - Timeout is reached when the counter equals IDLE_TIMEOUT.
- Latency, sleep (ISO_CYC=2, busy=0, sleep_req rises at cycle 0): DRAIN at 1, ISO at 2–3, SAVE at 4, OFF at 5, so alu_pwr_en=0 at cycle 5.
- Latency, wake (PWRUP_CYC=4, wake_req rises at cycle 0 in OFF): PWRUP at 1–4, RESTORE at 5, ON at 6.

Decomposition:
- Package alu_pmu_pkg holds the state encoding localparams, the opcode constants for MUL (4'b1000) and DIV (4'b1001) shared with the ALU, and the default delay values.
- One sub-module, pmu_delay_timer: a CNT_W-bit load/count/done counter, instanced once. ISO and PWRUP share it because those states are mutually exclusive.

Test Plan:
1. Reset, then sleep_req=1 with alu_busy=0, ISO_CYC=2 -> iso_en rises at cycle 2, save pulses at cycle 4 only, alu_pwr_en=0 and sleep_ack=1 from cycle 5.
2. From OFF, wake_req=1, PWRUP_CYC=4 -> alu_pwr_en=1 at cycle 1, restore pulses at cycle 5, iso_en=0 and pwr_ready=1 at cycle 6.
3. DIV in flight (alu_busy=1 for 9 cycles) plus sleep_req -> FSM stays in DRAIN until busy falls; start_in pulses during DRAIN give alu_start=0; iso_en only rises after busy falls.
4. In DRAIN, wake_req=1 -> back to ON next cycle with no save pulse; sleep_req and wake_req both high in ON -> stays ON.
5. IDLE_TIMEOUT=5, no activity -> DRAIN entered after 5 idle cycles; a start_in at idle cycle 3 restarts the count.
6. rst_n asserted during PWRUP -> asynchronously ON, alu_pwr_en=1, iso_en=0, restore=0.
